gb_apu_frame_sequencer: RTL and testbench

Generates the 512 Hz frame-sequencer strobes that drive the APU channel function blocks: length counters, volume envelopes and the channel-1 frequency sweep. It divides the system clock down to a step tick and walks an 8-step sequence. On each step it emits one-cycle strobes on `clk_length_ctr`, `clk_vol_env` and `clk_sweep`. It sits at the APU top level and fans out to every channel's length, envelope and sweep functions.

---
 rtl/gb_apu_pkg.sv | 21 ++
 rtl/gb_apu_prescaler.sv | 33 +++
 rtl/gb_apu_frame_sequencer.sv | 70 +++++++
 tb/tb_gb_apu_frame_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gb_apu_pkg.sv
// Shared APU types and constants for the frame sequencer and its users.
package gb_apu_pkg;

  typedef logic [2:0] fs_step_t;

  localparam fs_step_t FS_STEP_SWEEP_A = 3'd2;
  localparam fs_step_t FS_STEP_SWEEP_B = 3'd6;
  localparam fs_step_t FS_STEP_ENV     = 3'd7;

  localparam int unsigned FS_CLK_DIV_DEFAULT = 8192;

  // Sequencer control states; the eight step states live in the step register.
  localparam logic [0:0] FS_IDLE = 1'b0;
  localparam logic [0:0] FS_RUN  = 1'b1;

  // Length counters are clocked on even steps.
  function automatic logic fs_is_length_step(input fs_step_t s);
    return ~s[0];
  endfunction

endpackage

// File: rtl/gb_apu_prescaler.sv
// Modulo-DIV counter with synchronous clear and enable; emits a one-cycle
// terminal-count pulse while sitting at DIV-1 (suppressed by clear).
module gb_apu_prescaler #(
  parameter int unsigned DIV = 8192
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tc
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  // Count while enabled, wrap at DIV-1; disable or clear forces zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = enable && !clear && (count == LAST);

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// 512 Hz frame sequencer: divides the system clock to a step tick and walks
// an 8-step sequence emitting length, sweep and envelope strobes.
module gb_apu_frame_sequencer
  import gb_apu_pkg::*;
#(
  parameter int unsigned CLK_DIV = FS_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic       div_reset,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_vol_env,
  output logic [2:0] step,
  output logic       length_next
);

  logic [0:0] state;
  logic       tc;
  logic       tick;
  fs_step_t   step_q;

  gb_apu_prescaler #(
    .DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (apu_enable),
    .clear  (div_reset),
    .tc     (tc)
  );

  // Control state follows apu_enable: IDLE while disabled, RUN otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FS_IDLE;
    end else begin
      state <= apu_enable ? FS_RUN : FS_IDLE;
    end
  end

  assign tick = tc && (state == FS_RUN);

  // Decode the current step into one-cycle strobes and advance on each tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q         <= '0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else if (!apu_enable) begin
      step_q         <= '0;
      clk_length_ctr <= 1'b0;
      clk_sweep      <= 1'b0;
      clk_vol_env    <= 1'b0;
    end else begin
      clk_length_ctr <= tick && fs_is_length_step(step_q);
      clk_sweep      <= tick && ((step_q == FS_STEP_SWEEP_A) || (step_q == FS_STEP_SWEEP_B));
      clk_vol_env    <= tick && (step_q == FS_STEP_ENV);
      if (tick) begin
        step_q <= step_q + 3'd1;
      end
    end
  end

  assign step        = step_q;
  assign length_next = fs_is_length_step(step_q);

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Self-checking bench for gb_apu_frame_sequencer with CLK_DIV = 4.
module tb_gb_apu_frame_sequencer;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       apu_enable = 1'b0;
  logic       div_reset = 1'b0;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_vol_env;
  logic [2:0] step;
  logic       length_next;

  gb_apu_frame_sequencer #(
    .CLK_DIV (DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .apu_enable     (apu_enable),
    .div_reset      (div_reset),
    .clk_length_ctr (clk_length_ctr),
    .clk_sweep      (clk_sweep),
    .clk_vol_env    (clk_vol_env),
    .step           (step),
    .length_next    (length_next)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-step strobe tables, bit i = step i.
  localparam logic [7:0] LEN_TBL = 8'h55;
  localparam logic [7:0] SWP_TBL = 8'h44;
  localparam logic [7:0] ENV_TBL = 8'h80;

  int unsigned m_pre  = 0;
  logic [2:0]  m_step = 3'd0;
  logic [7:0]  sb_q[$];

  always @(posedge clk) begin : model
    logic        l, s, e;
    logic [2:0]  ns;
    int unsigned np;
    l  = 1'b0;
    s  = 1'b0;
    e  = 1'b0;
    ns = m_step;
    np = m_pre;
    if (reset || !apu_enable) begin
      np = 0;
      ns = 3'd0;
    end else begin
      if (m_pre == DIV - 1 && !div_reset) begin
        l  = LEN_TBL[m_step];
        s  = SWP_TBL[m_step];
        e  = ENV_TBL[m_step];
        ns = m_step + 3'd1;
      end
      np = div_reset ? 0 : ((m_pre == DIV - 1) ? 0 : m_pre + 1);
    end
    m_pre  <= np;
    m_step <= ns;
    sb_q.push_back({1'b0, l, s, e, ns, ~ns[0]});
  end

  // Scoreboard compare and strobe-width check, away from the active edge.
  logic p_len = 1'b0, p_swp = 1'b0, p_env = 1'b0;

  always @(negedge clk) begin : sampler
    logic [7:0] exp_v;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      check("sb", {1'b0, clk_length_ctr, clk_sweep, clk_vol_env, step, length_next}, exp_v);
    end
    check("width", {5'b0, clk_length_ctr & p_len, clk_sweep & p_swp, clk_vol_env & p_env}, 8'h00);
    p_len <= clk_length_ctr;
    p_swp <= clk_sweep;
    p_env <= clk_vol_env;
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  int unsigned n, cyc, last, c_len, c_swp, c_env, c_any;
  logic [2:0]  s0, prev_step;

  initial begin
    repeat (2) cycle();
    reset = 1'b0;
    apu_enable = 1'b1;

    // 40 enabled cycles: tick every 4, strobe counts over 10 ticks.
    c_len = 0; c_swp = 0; c_env = 0; last = 0;
    prev_step = step;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (clk_length_ctr) c_len++;
      if (clk_sweep) c_swp++;
      if (clk_vol_env) c_env++;
      if (step != prev_step) begin
        check("tick_ival", 8'(i - last), 8'(DIV));
        last = i;
      end
      prev_step = step;
    end
    check("len_cnt", 8'(c_len), 8'd5);
    check("swp_cnt", 8'(c_swp), 8'd2);
    check("env_cnt", 8'(c_env), 8'd1);

    // div_reset in the terminal-count cycle suppresses that tick.
    n = 0;
    while (m_pre != DIV - 1 && n < 10) begin cycle(); n++; end
    if (n >= 10) check("to_pre", 8'd1, 8'd0);
    div_reset = 1'b1;
    s0 = step;
    cycle();
    div_reset = 1'b0;
    check("dr_hold", {1'b0, clk_length_ctr, clk_sweep, clk_vol_env, 1'b0, step}, {5'b0, s0});
    n = 0;
    while (step == s0 && n < 10) begin cycle(); n++; end
    check("dr_lat", 8'(n), 8'(DIV));

    // Drop enable at step 5, hold 20 cycles, then re-enable.
    n = 0;
    while (m_step != 3'd5 && n < 40) begin cycle(); n++; end
    if (n >= 40) check("to_s5", 8'd1, 8'd0);
    apu_enable = 1'b0;
    cycle();
    check("dis_step", {5'b0, step}, 8'd0);
    c_any = 0;
    repeat (20) begin
      cycle();
      if (clk_length_ctr || clk_sweep || clk_vol_env) c_any++;
    end
    check("dis_quiet", 8'(c_any), 8'd0);
    apu_enable = 1'b1;
    n = 0;
    while (!clk_length_ctr && n < 10) begin cycle(); n++; end
    check("reen_lat", 8'(n), 8'(DIV));
    check("reen_step", {5'b0, step}, 8'd1);

    // div_reset held high for 20 cycles: no ticks, step frozen.
    s0 = step;
    div_reset = 1'b1;
    c_any = 0;
    repeat (20) begin
      cycle();
      if (clk_length_ctr || clk_sweep || clk_vol_env) c_any++;
    end
    check("dr_quiet", 8'(c_any), 8'd0);
    check("dr_step", {5'b0, step}, {5'b0, s0});
    div_reset = 1'b0;

    // Async reset between edges at step 6.
    n = 0;
    while (m_step != 3'd6 && n < 60) begin cycle(); n++; end
    if (n >= 60) check("to_s6", 8'd1, 8'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("async_rst", {1'b0, clk_length_ctr, clk_sweep, clk_vol_env, step, length_next}, 8'h01);
    cycle();
    cycle();
    reset = 1'b0;
    repeat (40) cycle();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
